field_cfg_streamer: RTL



---
 rtl/field_cfg_streamer_pkg.sv | 26 ++
 rtl/field_cfg_streamer_if.sv | 35 +++
 rtl/field_cfg_streamer_skid_fifo.sv | 42 ++++
 rtl/field_cfg_streamer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/field_cfg_streamer_pkg.sv
// Shared types and elaboration helpers for the field configuration streamer.
package field_cfg_pkg;

  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_DUMP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP,
    DRAIN
  } state_e;

  // Address width for a dimension of n cells; never narrower than one bit.
  function automatic int adr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A row must split into whole beats.
  function automatic bit lanes_fit(input int field_w, input int lanes);
    return (lanes >= 1) && ((field_w % lanes) == 0);
  endfunction

endpackage

// File: rtl/field_cfg_streamer_if.sv
// Load stream, field-memory port and dump stream of the field streamer.
// The master modport is the streamer side; slave is the host/memory side.
interface field_cfg_streamer_if
  import field_cfg_pkg::*;
#(
  parameter int FIELD_W = 8,
  parameter int FIELD_H = 8,
  parameter int LANES   = 1
);
  localparam int X_ADR_SIZE = adr_w(FIELD_W);
  localparam int Y_ADR_SIZE = adr_w(FIELD_H);

  logic [LANES-1:0]      i_data;
  logic                  i_valid;
  logic                  o_ready;
  logic                  o_we;
  logic [LANES-1:0]      o_wdata;
  logic                  o_re;
  logic [LANES-1:0]      i_rdata;
  logic [X_ADR_SIZE-1:0] o_cur_x;
  logic [Y_ADR_SIZE-1:0] o_cur_y;
  logic [LANES-1:0]      o_data;
  logic                  o_valid;
  logic                  i_ready;

  modport master (
    input  i_data, i_valid, i_rdata, i_ready,
    output o_ready, o_we, o_wdata, o_re, o_cur_x, o_cur_y, o_data, o_valid
  );

  modport slave (
    output i_data, i_valid, i_rdata, i_ready,
    input  o_ready, o_we, o_wdata, o_re, o_cur_x, o_cur_y, o_data, o_valid
  );
endinterface

// File: rtl/field_cfg_streamer_skid_fifo.sv
// Two-entry valid/ready FIFO with synchronous flush; holds read data on
// the dump path so the head stays stable under backpressure.
module cfg_skid_fifo #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // Pointer and occupancy bookkeeping; flush empties without touching data.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;
endmodule

// File: rtl/field_cfg_streamer.sv
// Streams the Game-of-Life field in row-major order, LANES cells per beat:
// LOAD turns a valid/ready cell stream into field writes, DUMP turns field
// reads into a valid/ready cell stream. Optional live-cell counter is
// enabled with the FIELD_CFG_POPCOUNT_EN macro.
module field_cfg_streamer
  import field_cfg_pkg::*;
#(
  parameter int  FIELD_W = 8,
  parameter int  FIELD_H = 8,
  parameter int  LANES   = 1,
  localparam int PC_W    = $clog2(FIELD_W * FIELD_H + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_go,
  input  logic                  i_mode,
  input  logic                  i_abort,
  field_cfg_streamer_if.master  bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [PC_W-1:0]       o_popcount
);
  localparam int X_ADR_SIZE = adr_w(FIELD_W);
  localparam int Y_ADR_SIZE = adr_w(FIELD_H);
  localparam int BEATS      = FIELD_W * FIELD_H / LANES;
  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - LANES);
  localparam logic [X_ADR_SIZE-1:0] X_STEP = X_ADR_SIZE'(LANES);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  if (!lanes_fit(FIELD_W, LANES) || FIELD_H < 1 || BEATS < 1) begin : g_bad_cfg
    $error("field_cfg_streamer: FIELD_W must be a multiple of LANES and FIELD_H >= 1");
  end

  state_e                state_q, state_d;
  logic [X_ADR_SIZE-1:0] x_q;
  logic [Y_ADR_SIZE-1:0] y_q;
  logic                  rd_vld_p1;
  logic                  done_q, done_d;
  logic                  ready, we, re, go_start, flush, pop, at_last;
  logic [1:0]            fifo_cnt;
  logic                  fifo_vld;
  logic [LANES-1:0]      fifo_head;
  logic [2:0]            occ;

  assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign flush   = i_abort && (state_q != IDLE);
  assign pop     = fifo_vld && bus.i_ready;
  // Entries owed to the FIFO after this cycle's pop: stored plus in flight.
  assign occ     = {1'b0, fifo_cnt} + {2'b0, rd_vld_p1} - {2'b0, pop};

  // Next state and handshake controls; abort masks every request.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    we       = 1'b0;
    re       = 1'b0;
    go_start = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_go && !i_abort) begin
          go_start = 1'b1;
          state_d  = (mode_e'(i_mode) == MODE_DUMP) ? DUMP : LOAD;
        end
      end
      LOAD: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          ready = 1'b1;
          we    = bus.i_valid;
          if (we && at_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      DUMP: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          re = (occ < 3'd2);
          if (re && at_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (occ == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, completion pulse and the read-in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      rd_vld_p1 <= re;
    end
  end

  // Row-major walk; the last beat keeps its address so it stays visible.
  always_ff @(posedge clk) begin
    if (rst || go_start) begin
      x_q <= '0;
      y_q <= '0;
    end else if ((we || re) && !at_last) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + X_STEP;
      end
    end
  end

  // ---- stage p1: read data returns one cycle after o_re ----
  cfg_skid_fifo #(.WIDTH(LANES)) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (rd_vld_p1),
    .push_data  (bus.i_rdata),
    .pop        (pop),
    .head_data  (fifo_head),
    .head_valid (fifo_vld),
    .count      (fifo_cnt)
  );

  assign bus.o_ready = ready;
  assign bus.o_we    = we;
  assign bus.o_wdata = bus.i_data;
  assign bus.o_re    = re;
  assign bus.o_cur_x = x_q;
  assign bus.o_cur_y = y_q;
  assign bus.o_data  = fifo_head;
  assign bus.o_valid = fifo_vld;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;

`ifdef FIELD_CFG_POPCOUNT_EN
  function automatic logic [PC_W-1:0] ones(input logic [LANES-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int k = 0; k < LANES; k++) n += PC_W'(v[k]);
    return n;
  endfunction

  logic [PC_W-1:0] pc_q;

  // Live-cell count of the beats that actually moved since the last go.
  always_ff @(posedge clk) begin
    if (rst || go_start) begin
      pc_q <= '0;
    end else if (we) begin
      pc_q <= pc_q + ones(bus.i_data);
    end else if (pop && state_q != IDLE) begin
      pc_q <= pc_q + ones(fifo_head);
    end
  end

  assign o_popcount = pc_q;
`else
  assign o_popcount = '0;
`endif
endmodule
